// File: rtl/lut_ram_fifo_ctrl.sv
// rtl/lut_ram_fifo_ctrl.sv - valid/ready FIFO controller driving an external LUT RAM with a registered output stage
module lut_ram_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       ram_write,
    output logic [$clog2(DEPTH)-1:0]   ram_waddr,
    output logic [WIDTH-1:0]           ram_wdata,
    output logic [$clog2(DEPTH)-1:0]   ram_raddr,
    input  logic [WIDTH-1:0]           ram_rdata,
    output logic [$clog2(DEPTH+2)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] ram_cnt;
    logic          push;
    logic          pop;
    logic          load;

    // in_ready looks only at registered occupancy, so a pop at full frees a slot one cycle later
    assign in_ready  = (ram_cnt != CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign ram_write = push & ~flush;
    assign load      = (ram_cnt != '0) & (~out_valid | pop) & ~flush;

    assign ram_waddr = wptr;
    assign ram_wdata = in_data;
    assign ram_raddr = rptr;
    assign count     = ram_cnt + CW'(out_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (ram_write) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
                rptr      <= rptr + 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            ram_cnt <= ram_cnt + CW'(ram_write) - CW'(load);
        end
    end

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        ram_cnt <= CW'(DEPTH));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        ram_write |-> in_ready);

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_data == $past(out_data)));

endmodule

// File: tb/tb_lut_ram_fifo_ctrl.sv
// tb/tb_lut_ram_fifo_ctrl.sv - directed vector bench for lut_ram_fifo_ctrl with a behavioural LUT RAM
module tb_lut_ram_fifo_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 2);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             ram_write;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_waddr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_raddr];

    lut_ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_write (ram_write),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .count     (count)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        int          e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] got [$];
        logic [31:0] sent [$];
        int accepted, first_pop, last_pop;

        // flush, in_valid, in_data, out_ready, exp out_valid, exp out_data, exp count, exp in_ready
        vecs[0]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,          1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001, 0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h11,        1'b0, 1'b0, 32'hA5A5_0001, 1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h22,        1'b0, 1'b1, 32'h11,        2, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h33,        1'b0, 1'b1, 32'h11,        3, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h22,        2, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h44,        1'b1, 1'b1, 32'h33,        2, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 32'h55,        1'b0, 1'b0, 32'h33,        0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h33,        0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h66,        1'b0, 1'b0, 32'h33,        1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h66,        1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h66,        0, 1'b1};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
            chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
            chk("idle_count", 32'(count), 32'd0);
            chk("idle_ram_write", {31'b0, ram_write}, 32'd0);
            step();
        end

        for (int i = 0; i < 13; i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
        end
        idle_inputs();
        step();

        // fill past capacity with the output stalled
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b0;
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        chk("full_accepted", 32'(accepted), 32'd17);
        chk("full_count", 32'(count), 32'd17);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) got.push_back(out_data);
            step();
        end
        chk("drain_len", 32'(got.size()), 32'd17);
        for (int i = 0; i < got.size() && i < 17; i++) chk($sformatf("drain_item%0d", i), got[i], 32'(i));
        chk("drain_count", 32'(count), 32'd0);

        // sustained streaming wraps pointers several times
        got.delete(); sent.delete();
        first_pop = -1; last_pop = -1;
        for (int c = 0; c < 110; c++) begin
            in_valid = (c < 100); in_data = 32'h1000 + 32'(c); out_ready = 1'b1;
            if (in_valid && in_ready) sent.push_back(in_data);
            if (out_valid) begin
                got.push_back(out_data);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            step();
        end
        idle_inputs();
        chk("stream_sent", 32'(sent.size()), 32'd100);
        chk("stream_got", 32'(got.size()), 32'd100);
        chk("stream_first_latency", 32'(first_pop), 32'd2);
        chk("stream_no_bubbles", 32'(last_pop - first_pop + 1), 32'(got.size()));
        for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            if (got[i] !== sent[i]) chk($sformatf("stream_item%0d", i), got[i], sent[i]);
        end

        // flush with a concurrent push drops everything, including that push
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'h500 + 32'(i);
            step();
        end
        chk("pre_flush_count", 32'(count), 32'd5);
        flush = 1'b1; in_data = 32'hDEAD;
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; in_data = 32'h77;
        step();
        in_valid = 1'b0;
        chk("post_flush_lat1_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("post_flush_lat2_valid", {31'b0, out_valid}, 32'd1);
        chk("post_flush_data", out_data, 32'h77);
        out_ready = 1'b1;
        step();
        idle_inputs();

        // asynchronous reset mid-stream with 8 entries queued
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'h800 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_reset_count", 32'(count), 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_reset_count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 3); in_data = 32'h900 + 32'(c); out_ready = 1'b1;
            if (out_valid) got.push_back(out_data);
            step();
        end
        idle_inputs();
        chk("post_reset_len", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("post_reset_item%0d", i), got[i], 32'h900 + 32'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
